// File: rtl/multi_cache_fill_ctrl.sv
// Block-fill controller shared by NUM_REQ caches: round-robin arbitration, burst read issue, in-order fill writes.
// Define CRITICAL_WORD_FIRST_EN to start issue and fill at the missed word instead of word 0.
module multi_cache_fill_ctrl #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_miss,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_data_valid,
  input  logic [DATA_W-1:0]         mem_data_in,
  output logic                      fill_we,
  output logic [ADDR_W-1:0]         fill_addr,
  output logic [DATA_W-1:0]         fill_data,
  output logic                      fill_tag_we
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK * BYTES);
  localparam int CNT_W = IDX_W + 1;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0]  WPB_C    = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] BYTES_A  = ADDR_W'(BYTES);
  localparam logic [PTR_W-1:0]  LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, gidx, arb_idx, cand;
  logic               arb_found;
  logic [NUM_REQ-1:0] grant_q;
  logic [ADDR_W-1:0]  base, sel_addr;
  logic [IDX_W-1:0]   start, crit_idx, issue_idx, ret_idx;
  logic [CNT_W-1:0]   icnt, rcnt;
  logic               issuing, accept;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!arb_found && req_miss[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign sel_addr = req_addr[arb_idx*ADDR_W +: ADDR_W];

`ifdef CRITICAL_WORD_FIRST_EN
  assign crit_idx = IDX_W'((sel_addr & ~BLK_MASK) / BYTES_A);
`else
  assign crit_idx = '0;
`endif

  // Word indices wrap inside the block, so the tag/index bits of base never change.
  assign issue_idx = start + icnt[IDX_W-1:0];
  assign ret_idx   = start + rcnt[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant       = '0;
    busy        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    fill_we     = 1'b0;
    fill_addr   = '0;
    fill_data   = '0;
    fill_tag_we = 1'b0;
    issuing     = (state == FILL) && (icnt < WPB_C);
    accept      = (state == FILL) && mem_data_valid && (rcnt < WPB_C);
    case (state)
      IDLE: if (arb_found) state_nxt = FILL;
      FILL: begin
        busy  = 1'b1;
        grant = grant_q;
        if (issuing) begin
          mem_rd_en = 1'b1;
          mem_addr  = base + ADDR_W'(issue_idx) * BYTES_A;
        end
        if (accept) begin
          fill_we   = 1'b1;
          fill_addr = base + ADDR_W'(ret_idx) * BYTES_A;
          fill_data = mem_data_in;
          if (rcnt == LAST_C) state_nxt = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        grant       = grant_q;
        fill_tag_we = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt   = IDLE;
      grant       = '0;
      busy        = 1'b0;
      mem_rd_en   = 1'b0;
      mem_addr    = '0;
      fill_we     = 1'b0;
      fill_addr   = '0;
      fill_data   = '0;
      fill_tag_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      gidx    <= '0;
      grant_q <= '0;
      base    <= '0;
      start   <= '0;
      icnt    <= '0;
      rcnt    <= '0;
    end else begin
      case (state)
        IDLE: if (arb_found) begin
          gidx    <= arb_idx;
          grant_q <= NUM_REQ'(1) << arb_idx;
          base    <= sel_addr & BLK_MASK;
          start   <= crit_idx;
          icnt    <= '0;
          rcnt    <= '0;
        end
        FILL: begin
          if (issuing) icnt <= icnt + CNT_W'(1);
          if (accept)  rcnt <= rcnt + CNT_W'(1);
        end
        DONE: rr_ptr <= (gidx == LAST_REQ) ? '0 : gidx + PTR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cache_fill_ctrl.sv
// Bench for multi_cache_fill_ctrl (NUM_REQ=2, 16-bit address/data, 8-word blocks); honours CRITICAL_WORD_FIRST_EN.
module tb_multi_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_miss;
  logic [31:0] req_addr;
  logic [1:0]  grant;
  logic        busy, mem_rd_en, mem_data_valid, fill_we, fill_tag_we;
  logic [15:0] mem_addr, mem_data_in, fill_addr, fill_data;

  int total = 0;
  int bad   = 0;
  int rr_m  = 0;

  multi_cache_fill_ctrl #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) dut (
    .clk(clk), .rst(rst), .req_miss(req_miss), .req_addr(req_addr), .grant(grant),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data), .fill_tag_we(fill_tag_we)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no-finish expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  req;
    logic [15:0] a0;
    logic [15:0] a1;
    int          mode;
    bit          hold;
    int          exp_g;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address of the k-th word of a fill for a miss at byte address a.
  function automatic logic [15:0] exp_addr(input logic [15:0] a, input int k);
    int s;
`ifdef CRITICAL_WORD_FIRST_EN
    s = int'(a[3:1]);
`else
    s = 0;
`endif
    return (a & 16'hFFF0) + 16'(((s + k) % 8) * 2);
  endfunction

  // Entered in an IDLE cycle with the request already driven; leaves in the IDLE cycle after DONE.
  // mode 0: return every issued word asap; 1: random gaps; 2: two-cycle gap after the 3rd word.
  task automatic do_fill(input int g, input logic [15:0] a, input int mode, input bit hold);
    int ret, c, gapc;
    bit v;
    logic [15:0] d;
    mem_data_valid = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
    chk("idle_fill_we", fill_we, 0);
    chk("idle_rd_en", mem_rd_en, 0);
    step();
    ret = 0; c = 0; gapc = 0;
    while (ret < 8 && c < 100) begin
      if (!hold && c == 1) req_miss = 2'b00;
      v = ret < ((c < 8) ? c : 8);
      if (mode == 1 && $urandom_range(0, 1) == 0) v = 1'b0;
      if (mode == 2 && ret == 3 && gapc < 2) begin
        v = 1'b0;
        gapc++;
      end
      d = 16'($urandom);
      mem_data_valid = v;
      mem_data_in = d;
      #1;
      chk("fill_grant", grant, 2'b01 << g);
      chk("fill_busy", busy, 1);
      chk("rd_en", mem_rd_en, c < 8);
      if (c < 8) chk("mem_addr", mem_addr, exp_addr(a, c));
      chk("fill_we", fill_we, v);
      if (v) begin
        chk("fill_addr", fill_addr, exp_addr(a, ret));
        chk("fill_data", fill_data, d);
        ret++;
      end
      chk("early_tag_we", fill_tag_we, 0);
      c++;
      step();
    end
    chk("fill_words", ret, 8);
    mem_data_valid = 1'b1;
    #1;
    chk("done_tag_we", fill_tag_we, 1);
    chk("done_busy", busy, 1);
    chk("done_grant", grant, 2'b01 << g);
    chk("done_fill_we", fill_we, 0);
    chk("done_rd_en", mem_rd_en, 0);
    rr_m = (g + 1) % 2;
    step();
    mem_data_valid = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    logic [15:0] a;
    logic [1:0]  rq;
    int g;

    tbl[0] = '{req: 2'b01, a0: 16'h1236, a1: 16'h0000, mode: 0, hold: 1'b0, exp_g: 0};
    tbl[1] = '{req: 2'b10, a0: 16'h0000, a1: 16'h4F1E, mode: 1, hold: 1'b0, exp_g: 1};
    tbl[2] = '{req: 2'b11, a0: 16'h0002, a1: 16'h8000, mode: 0, hold: 1'b1, exp_g: 0};
    tbl[3] = '{req: 2'b11, a0: 16'h0002, a1: 16'h8000, mode: 2, hold: 1'b0, exp_g: 1};
    tbl[4] = '{req: 2'b10, a0: 16'h5555, a1: 16'hFFFE, mode: 0, hold: 1'b0, exp_g: 1};
    tbl[5] = '{req: 2'b01, a0: 16'hABCF, a1: 16'h1111, mode: 1, hold: 1'b0, exp_g: 0};
    tbl[6] = '{req: 2'b01, a0: 16'h123A, a1: 16'h2222, mode: 2, hold: 1'b0, exp_g: 0};
    tbl[7] = '{req: 2'b11, a0: 16'h7008, a1: 16'h9ABC, mode: 0, hold: 1'b0, exp_g: 1};

    // Reset with live inputs: every output must stay quiet.
    rst = 1'b1; req_miss = 2'b01; req_addr = 32'h0000_1236;
    mem_data_valid = 1'b1; mem_data_in = 16'hBEEF;
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_fill_we", fill_we, 0);
    chk("rst_tag_we", fill_tag_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_addr", fill_addr, 0);
    chk("rst_fill_data", fill_data, 0);
    rst = 1'b0; req_miss = 2'b00; mem_data_valid = 1'b0;
    rr_m = 0;

    for (int i = 0; i < 8; i++) begin
      req_miss = tbl[i].req;
      req_addr = {tbl[i].a1, tbl[i].a0};
      a = (tbl[i].exp_g == 1) ? tbl[i].a1 : tbl[i].a0;
      do_fill(tbl[i].exp_g, a, tbl[i].mode, tbl[i].hold);
    end
    #1;
    chk("table_end_busy", busy, 0);

    // Both caches missing continuously from reset: 01, 10, 01.
    rst = 1'b1;
    step();
    rst = 1'b0; req_miss = 2'b11; req_addr = {16'hC0DE, 16'h3004};
    rr_m = 0;
    do_fill(0, 16'h3004, 0, 1'b1);
    do_fill(1, 16'hC0DE, 1, 1'b1);
    do_fill(0, 16'h3004, 0, 1'b1);
    req_miss = 2'b00;

    // Reset mid-fill after three returned words.
    rst = 1'b1;
    step();
    rst = 1'b0; req_miss = 2'b01; req_addr = {16'h0000, 16'h2224};
    step();
    for (int c = 0; c < 4; c++) begin
      mem_data_valid = (c > 0);
      mem_data_in = 16'($urandom);
      #1;
      if (c > 0) chk("abort_fill_addr", fill_addr, exp_addr(16'h2224, c - 1));
      step();
    end
    rst = 1'b1; mem_data_valid = 1'b1;
    #1;
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_grant", grant, 0);
    chk("abort_rst_fill_we", fill_we, 0);
    chk("abort_rst_tag_we", fill_tag_we, 0);
    chk("abort_rst_rd_en", mem_rd_en, 0);
    step();
    rst = 1'b0; req_miss = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_grant", grant, 0);
      chk("abort_fill_we", fill_we, 0);
      chk("abort_tag_we", fill_tag_we, 0);
      step();
    end
    mem_data_valid = 1'b0;
    rr_m = 0;
    req_miss = 2'b01;
    do_fill(0, 16'h2224, 0, 1'b0);

    // Random traffic against the round-robin reference.
    for (int n = 0; n < 25; n++) begin
      req_miss = 2'b00;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        mem_data_valid = 1'($urandom);
        #1;
        chk("rand_idle_fill_we", fill_we, 0);
        chk("rand_idle_busy", busy, 0);
        step();
      end
      rq = 2'($urandom_range(1, 3));
      req_miss = rq;
      req_addr = $urandom;
      g = rq[rr_m] ? rr_m : (rr_m + 1) % 2;
      a = (g == 1) ? req_addr[31:16] : req_addr[15:0];
      do_fill(g, a, int'($urandom_range(0, 2)), 1'($urandom));
    end
    req_miss = 2'b00;
    #1;
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
